// File: rtl/id_operand_pkg.sv
// Shared types and helpers for the decode-stage operand unit.
package id_operand_pkg;

  typedef enum logic [1:0] {
    FWD_FILE = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_EX   = 2'd3
  } forwardSelect_t;

  localparam int ZERO_REGISTER = 0;
  localparam int NUM_OPERANDS  = 2;

  // A producer feeds a consumer only when it writes, the addresses agree and
  // the consumer is not reading the hardwired zero register.
  function automatic logic forwardMatch(input logic writeEnable,
                                        input logic addressEqual,
                                        input logic sourceNonZero);
    return writeEnable & addressEqual & sourceNonZero;
  endfunction

endpackage

// File: rtl/operand_register_file.sv
// Register array with async clear, one write port and NUM_OPERANDS read ports
// that see a same-cycle write (write-through bypass). Register 0 reads as zero.
module operand_register_file
  import id_operand_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             writeEnable,
  input  logic [REG_ADDR_WIDTH-1:0]                        writeAddress,
  input  logic [DATA_WIDTH-1:0]                            writeData,
  input  logic [NUM_OPERANDS-1:0][REG_ADDR_WIDTH-1:0]      readAddress,
  output logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]          readData,
  output logic [(2**REG_ADDR_WIDTH)*DATA_WIDTH-1:0]        debugRegisters
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(ZERO_REGISTER);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] registers;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) registers <= '0;
    else if (writeEnable && writeAddress != ZERO_ADDR) registers[writeAddress] <= writeData;
  end

  for (genvar p = 0; p < NUM_OPERANDS; p++) begin : gRead
    logic [DATA_WIDTH-1:0] value;
    always_comb begin
      value = registers[readAddress[p]];
      if (readAddress[p] == ZERO_ADDR) value = '0;
      else if (forwardMatch(writeEnable, writeAddress == readAddress[p], 1'b1)) value = writeData;
    end
    assign readData[p] = value;
  end

  assign debugRegisters = registers;

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: register file, EX/MEM/WB forwarding, load-use stall
// and the ID/EX operand register. Define ID_OPERAND_PERF_COUNTERS_EN to add
// stallCycleCount/forwardCount outputs.
module id_operand_stage
  import id_operand_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int MEM_LOAD_FORWARD = 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      idValid,
  input  logic [REG_ADDR_WIDTH-1:0]                 idRsAddress,
  input  logic [REG_ADDR_WIDTH-1:0]                 idRtAddress,
  input  logic                                      idUsesRs,
  input  logic                                      idUsesRt,
  input  logic                                      exShouldWriteRegister,
  input  logic                                      exIsLoad,
  input  logic [REG_ADDR_WIDTH-1:0]                 exRegisterWriteAddress,
  input  logic [DATA_WIDTH-1:0]                     exResult,
  input  logic                                      memShouldWriteRegister,
  input  logic                                      memIsLoad,
  input  logic [REG_ADDR_WIDTH-1:0]                 memRegisterWriteAddress,
  input  logic [DATA_WIDTH-1:0]                     memResult,
  input  logic                                      wbShouldWriteRegister,
  input  logic [REG_ADDR_WIDTH-1:0]                 wbRegisterWriteAddress,
  input  logic [DATA_WIDTH-1:0]                     wbRegisterWriteData,
  input  logic                                      flush,
  output logic                                      shouldStall,
  output logic [DATA_WIDTH-1:0]                     registerRs,
  output logic [DATA_WIDTH-1:0]                     registerRt,
  output logic                                      outValid,
  output logic [DATA_WIDTH-1:0]                     outRegisterRs,
  output logic [DATA_WIDTH-1:0]                     outRegisterRt,
  output logic [(2**REG_ADDR_WIDTH)*DATA_WIDTH-1:0] debug_registers
`ifdef ID_OPERAND_PERF_COUNTERS_EN
  ,
  output logic [31:0]                               stallCycleCount,
  output logic [31:0]                               forwardCount
`endif
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(ZERO_REGISTER);
  localparam logic MEM_FWD_LOADS = (MEM_LOAD_FORWARD != 0);

  logic [NUM_OPERANDS-1:0][REG_ADDR_WIDTH-1:0] srcAddress;
  logic [NUM_OPERANDS-1:0]                     srcUsed;
  logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]     fileData;
  logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]     operand;
  logic [NUM_OPERANDS-1:0]                     loadHazard;
  logic                                        capture;

  assign srcAddress = {idRtAddress, idRsAddress};
  assign srcUsed    = {idUsesRt, idUsesRs};

  operand_register_file #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) uRegisterFile (
    .clock         (clock),
    .reset         (reset),
    .writeEnable   (wbShouldWriteRegister),
    .writeAddress  (wbRegisterWriteAddress),
    .writeData     (wbRegisterWriteData),
    .readAddress   (srcAddress),
    .readData      (fileData),
    .debugRegisters(debug_registers)
  );

`ifdef ID_OPERAND_PERF_COUNTERS_EN
  logic [NUM_OPERANDS-1:0] forwarded;
`endif

  for (genvar p = 0; p < NUM_OPERANDS; p++) begin : gOperand
    logic           nonZero, exHit, memHit, wbHit;
    forwardSelect_t select;
    logic [DATA_WIDTH-1:0] value;

    assign nonZero = srcAddress[p] != ZERO_ADDR;
    assign exHit   = forwardMatch(exShouldWriteRegister & ~exIsLoad,
                                  exRegisterWriteAddress == srcAddress[p], nonZero);
    assign memHit  = forwardMatch(memShouldWriteRegister & (MEM_FWD_LOADS | ~memIsLoad),
                                  memRegisterWriteAddress == srcAddress[p], nonZero);
    assign wbHit   = forwardMatch(wbShouldWriteRegister,
                                  wbRegisterWriteAddress == srcAddress[p], nonZero);

    always_comb begin
      select = FWD_FILE;
      if (exHit)       select = FWD_EX;
      else if (memHit) select = FWD_MEM;
      else if (wbHit)  select = FWD_WB;
    end

    // The WB bypass lives in the register file read port, so FWD_WB reads it too.
    always_comb begin
      case (select)
        FWD_EX:  value = exResult;
        FWD_MEM: value = memResult;
        default: value = fileData[p];
      endcase
    end

    assign operand[p] = value;
    assign loadHazard[p] = srcUsed[p] &
      (forwardMatch(exShouldWriteRegister & exIsLoad,
                    exRegisterWriteAddress == srcAddress[p], nonZero) |
       forwardMatch(memShouldWriteRegister & memIsLoad & ~MEM_FWD_LOADS,
                    memRegisterWriteAddress == srcAddress[p], nonZero));
`ifdef ID_OPERAND_PERF_COUNTERS_EN
    assign forwarded[p] = srcUsed[p] & (select != FWD_FILE);
`endif
  end

  assign registerRs  = operand[0];
  assign registerRt  = operand[1];
  assign shouldStall = idValid & ~flush & (|loadHazard);
  assign capture     = ~flush & ~shouldStall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outValid      <= 1'b0;
      outRegisterRs <= '0;
      outRegisterRt <= '0;
    end else if (!capture) begin
      outValid      <= 1'b0;
      outRegisterRs <= '0;
      outRegisterRt <= '0;
    end else begin
      outValid      <= idValid;
      outRegisterRs <= operand[0];
      outRegisterRt <= operand[1];
    end
  end

`ifdef ID_OPERAND_PERF_COUNTERS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stallCycleCount <= '0;
      forwardCount    <= '0;
    end else begin
      if (shouldStall) stallCycleCount <= stallCycleCount + 32'd1;
      if (capture && idValid && (|forwarded)) forwardCount <= forwardCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: two instances (memory-stage load forwarding on/off)
// share stimulus and are checked against a behavioural model.
module tb_id_operand_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        idValid, idUsesRs, idUsesRt, flush;
  logic [4:0]  idRsAddress, idRtAddress;
  logic        exWe, exLoad, memWe, memLoad, wbWe;
  logic [4:0]  exAddr, memAddr, wbAddr;
  logic [31:0] exRes, memRes, wbData;

  logic          stall1, outValid1, stall0, outValid0;
  logic [31:0]   regRs1, regRt1, outRs1, outRt1, regRs0, regRt0, outRs0, outRt0;
  logic [1023:0] dbg1, dbg0;
`ifdef ID_OPERAND_PERF_COUNTERS_EN
  logic [31:0]   stallCnt1, fwdCnt1, stallCnt0, fwdCnt0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  bit          expValid [2];
  logic [31:0] expRs [2], expRt [2], expStallCnt [2], expFwdCnt [2];

  always #5 clock = ~clock;

  id_operand_stage #(.MEM_LOAD_FORWARD(1)) u1 (
    .clock(clock), .reset(reset), .idValid(idValid),
    .idRsAddress(idRsAddress), .idRtAddress(idRtAddress),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exShouldWriteRegister(exWe), .exIsLoad(exLoad),
    .exRegisterWriteAddress(exAddr), .exResult(exRes),
    .memShouldWriteRegister(memWe), .memIsLoad(memLoad),
    .memRegisterWriteAddress(memAddr), .memResult(memRes),
    .wbShouldWriteRegister(wbWe), .wbRegisterWriteAddress(wbAddr),
    .wbRegisterWriteData(wbData), .flush(flush),
    .shouldStall(stall1), .registerRs(regRs1), .registerRt(regRt1),
    .outValid(outValid1), .outRegisterRs(outRs1), .outRegisterRt(outRt1),
    .debug_registers(dbg1)
`ifdef ID_OPERAND_PERF_COUNTERS_EN
    , .stallCycleCount(stallCnt1), .forwardCount(fwdCnt1)
`endif
  );

  id_operand_stage #(.MEM_LOAD_FORWARD(0)) u0 (
    .clock(clock), .reset(reset), .idValid(idValid),
    .idRsAddress(idRsAddress), .idRtAddress(idRtAddress),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exShouldWriteRegister(exWe), .exIsLoad(exLoad),
    .exRegisterWriteAddress(exAddr), .exResult(exRes),
    .memShouldWriteRegister(memWe), .memIsLoad(memLoad),
    .memRegisterWriteAddress(memAddr), .memResult(memRes),
    .wbShouldWriteRegister(wbWe), .wbRegisterWriteAddress(wbAddr),
    .wbRegisterWriteData(wbData), .flush(flush),
    .shouldStall(stall0), .registerRs(regRs0), .registerRt(regRt0),
    .outValid(outValid0), .outRegisterRs(outRs0), .outRegisterRt(outRt0),
    .debug_registers(dbg0)
`ifdef ID_OPERAND_PERF_COUNTERS_EN
    , .stallCycleCount(stallCnt0), .forwardCount(fwdCnt0)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwdVal(input logic [4:0] a, input bit mlf);
    if (a == 5'd0) return 32'd0;
    if (exWe && exAddr == a && !exLoad) return exRes;
    if (memWe && memAddr == a && (mlf || !memLoad)) return memRes;
    if (wbWe && wbAddr == a) return wbData;
    return mregs[a];
  endfunction

  function automatic bit fromBypass(input logic [4:0] a, input bit mlf);
    if (a == 5'd0) return 1'b0;
    return (exWe && exAddr == a && !exLoad) || (memWe && memAddr == a && (mlf || !memLoad)) ||
           (wbWe && wbAddr == a);
  endfunction

  function automatic bit loadHaz(input logic [4:0] a, input bit mlf);
    if (a == 5'd0) return 1'b0;
    return (exWe && exLoad && exAddr == a) || (!mlf && memWe && memLoad && memAddr == a);
  endfunction

  function automatic bit expStall(input bit mlf);
    return idValid && !flush && ((idUsesRs && loadHaz(idRsAddress, mlf)) ||
                                 (idUsesRt && loadHaz(idRtAddress, mlf)));
  endfunction

  function automatic logic [1023:0] flatRegs();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = mregs[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    for (int m = 0; m < 2; m++) begin
      expValid[m] = 1'b0; expRs[m] = 32'd0; expRt[m] = 32'd0;
      expStallCnt[m] = 32'd0; expFwdCnt[m] = 32'd0;
    end
  endtask

  task automatic clearInputs();
    idValid = 0; idUsesRs = 0; idUsesRt = 0; flush = 0;
    idRsAddress = 0; idRtAddress = 0;
    exWe = 0; exLoad = 0; exAddr = 0; exRes = 0;
    memWe = 0; memLoad = 0; memAddr = 0; memRes = 0;
    wbWe = 0; wbAddr = 0; wbData = 0;
  endtask

  // Advance one clock, updating model expectations from the pre-edge inputs.
  task automatic tick();
    bit st, mlf;
    for (int m = 0; m < 2; m++) begin
      mlf = (m == 1);
      st = expStall(mlf);
      if (flush || st) begin
        expValid[m] = 1'b0; expRs[m] = 32'd0; expRt[m] = 32'd0;
      end else begin
        expValid[m] = idValid;
        expRs[m] = fwdVal(idRsAddress, mlf);
        expRt[m] = fwdVal(idRtAddress, mlf);
      end
      if (st) expStallCnt[m] = expStallCnt[m] + 32'd1;
      if (!flush && !st && idValid && ((idUsesRs && fromBypass(idRsAddress, mlf)) ||
                                       (idUsesRt && fromBypass(idRtAddress, mlf))))
        expFwdCnt[m] = expFwdCnt[m] + 32'd1;
    end
    if (wbWe && wbAddr != 5'd0) mregs[wbAddr] = wbData;
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clearInputs();
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({outValid1, outRs1, outRt1, outValid0, outRs0, outRt0} !== 130'd0) begin
      errors++;
      $display("FAIL reset_idex: got u1 v=%0b rs=%h rt=%h u0 v=%0b rs=%h rt=%h, want all 0",
               outValid1, outRs1, outRt1, outValid0, outRs0, outRt0);
    end
    checks++;
    if (dbg1 !== '0 || dbg0 !== '0) begin
      errors++; $display("FAIL reset_regs: debug_registers nonzero, want 0");
    end
    checks++;
    if (stall1 !== 1'b0 || stall0 !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %0b/%0b want 0/0", stall1, stall0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_regfile();
    clearInputs();
    idValid = 1; idUsesRs = 1; idRsAddress = 5'd5;
    wbWe = 1; wbAddr = 5'd5; wbData = 32'h1234;
    tick();
    wbWe = 0;
    #1;
    checks++;
    if (regRs1 !== 32'h1234 || regRs0 !== 32'h1234) begin
      errors++; $display("FAIL rf_read: got %h/%h want 00001234", regRs1, regRs0);
    end
    idUsesRt = 1; idRtAddress = 5'd6;
    wbWe = 1; wbAddr = 5'd6; wbData = 32'hABCD;
    #1;
    checks++;
    if (regRt1 !== 32'hABCD || regRt0 !== 32'hABCD) begin
      errors++; $display("FAIL rf_bypass: got %h/%h want 0000abcd", regRt1, regRt0);
    end
    tick();
    checks++;
    if (outRt1 !== 32'hABCD || dbg1[6*32 +: 32] !== 32'hABCD) begin
      errors++; $display("FAIL rf_write: got out=%h r6=%h want 0000abcd", outRt1, dbg1[6*32 +: 32]);
    end
    idRsAddress = 5'd0; wbAddr = 5'd0; wbData = 32'hFFFF;
    #1;
    checks++;
    if (regRs1 !== 32'd0) begin
      errors++; $display("FAIL rf_r0_bypass: got %h want 0", regRs1);
    end
    tick();
    wbWe = 0;
    #1;
    checks++;
    if (regRs1 !== 32'd0 || dbg1[31:0] !== 32'd0 || dbg0[31:0] !== 32'd0) begin
      errors++; $display("FAIL rf_r0: got rs=%h r0=%h want 0", regRs1, dbg1[31:0]);
    end
  endtask

  task automatic test_forwarding();
    clearInputs();
    idValid = 1; idUsesRs = 1; idRsAddress = 5'd3;
    exWe = 1; exAddr = 5'd3; exRes = 32'h10;
    memWe = 1; memAddr = 5'd3; memRes = 32'h20;
    wbWe = 1; wbAddr = 5'd3; wbData = 32'h30;
    #1;
    checks++;
    if (regRs1 !== 32'h10 || regRs0 !== 32'h10) begin
      errors++; $display("FAIL fwd_ex: got %h/%h want 10", regRs1, regRs0);
    end
    exWe = 0;
    #1;
    checks++;
    if (regRs1 !== 32'h20 || regRs0 !== 32'h20) begin
      errors++; $display("FAIL fwd_mem: got %h/%h want 20", regRs1, regRs0);
    end
    memWe = 0;
    #1;
    checks++;
    if (regRs1 !== 32'h30 || regRs0 !== 32'h30) begin
      errors++; $display("FAIL fwd_wb: got %h/%h want 30", regRs1, regRs0);
    end
    tick();
    checks++;
    if (outRs1 !== 32'h30 || outValid1 !== 1'b1) begin
      errors++; $display("FAIL fwd_capture: got v=%0b rs=%h want 1/30", outValid1, outRs1);
    end
    // MEM-stage load: forwarded only when loads may bypass from MEM
    memWe = 1; memLoad = 1; memAddr = 5'd3; memRes = 32'h77;
    wbData = 32'h99;
    #1;
    checks++;
    if (regRs1 !== 32'h77 || regRs0 !== 32'h99 || stall1 !== 1'b0 || stall0 !== 1'b1) begin
      errors++; $display("FAIL fwd_memload: got %h/%h stall %0b/%0b want 77/99 0/1",
                         regRs1, regRs0, stall1, stall0);
    end
    idUsesRs = 0;
    #1;
    checks++;
    if (stall0 !== 1'b0 || regRs0 !== 32'h99) begin
      errors++; $display("FAIL fwd_unused: got stall=%0b rs=%h want 0/99", stall0, regRs0);
    end
    tick();
  endtask

  task automatic test_load_use();
    clearInputs();
    idValid = 1; idUsesRt = 1; idRtAddress = 5'd4;
    exWe = 1; exLoad = 1; exAddr = 5'd4;
    #1;
    checks++;
    if (stall1 !== 1'b1 || stall0 !== 1'b1) begin
      errors++; $display("FAIL lu_ex_stall: got %0b/%0b want 1/1", stall1, stall0);
    end
    tick();
    checks++;
    if (outValid1 !== 1'b0 || outValid0 !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got %0b/%0b want 0/0", outValid1, outValid0);
    end
    exWe = 0; exLoad = 0;
    memWe = 1; memLoad = 1; memAddr = 5'd4; memRes = 32'h55;
    #1;
    checks++;
    if (stall1 !== 1'b0 || stall0 !== 1'b1) begin
      errors++; $display("FAIL lu_mem_stall: got %0b/%0b want 0/1", stall1, stall0);
    end
    tick();
    checks++;
    if (outValid1 !== 1'b1 || outRt1 !== 32'h55 || outValid0 !== 1'b0) begin
      errors++; $display("FAIL lu_issue1: got u1 v=%0b rt=%h u0 v=%0b want 1/55/0",
                         outValid1, outRt1, outValid0);
    end
    memWe = 0; memLoad = 0;
    wbWe = 1; wbAddr = 5'd4; wbData = 32'h55;
    #1;
    checks++;
    if (stall0 !== 1'b0 || regRt0 !== 32'h55) begin
      errors++; $display("FAIL lu_wb: got stall=%0b rt=%h want 0/55", stall0, regRt0);
    end
    tick();
    checks++;
    if (outValid0 !== 1'b1 || outRt0 !== 32'h55) begin
      errors++; $display("FAIL lu_issue0: got v=%0b rt=%h want 1/55", outValid0, outRt0);
    end
  endtask

  task automatic test_flush_reset();
    clearInputs();
    idValid = 1; idUsesRs = 1; idRsAddress = 5'd2;
    tick();
    exWe = 1; exLoad = 1; exAddr = 5'd2; flush = 1;
    #1;
    checks++;
    if (stall1 !== 1'b0 || stall0 !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %0b/%0b want 0/0", stall1, stall0);
    end
    tick();
    checks++;
    if (outValid1 !== 1'b0 || outValid0 !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got %0b/%0b want 0/0", outValid1, outValid0);
    end
    exWe = 0; flush = 0;
    tick();
    exWe = 1; exLoad = 1; exAddr = 5'd2;
    #1;
    checks++;
    if (stall1 !== 1'b1 || outValid1 !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got stall=%0b v=%0b want 1/1", stall1, outValid1);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outValid1 !== 1'b0 || outValid0 !== 1'b0 || dbg1 !== '0 || dbg0 !== '0) begin
      errors++; $display("FAIL async_reset: got v=%0b/%0b regs_zero=%0b/%0b want 0/0 1/1",
                         outValid1, outValid0, dbg1 == '0, dbg0 == '0);
    end
    modelReset();
    clearInputs();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      idValid = ($urandom_range(0, 7) != 0);
      idUsesRs = $urandom_range(0, 1); idUsesRt = $urandom_range(0, 1);
      idRsAddress = 5'($urandom_range(0, 7)); idRtAddress = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 7) == 0);
      exWe = $urandom_range(0, 1); exLoad = ($urandom_range(0, 2) == 0);
      exAddr = 5'($urandom_range(0, 7)); exRes = $urandom;
      memWe = $urandom_range(0, 1); memLoad = ($urandom_range(0, 2) == 0);
      memAddr = 5'($urandom_range(0, 7)); memRes = $urandom;
      wbWe = $urandom_range(0, 1); wbAddr = 5'($urandom_range(0, 7)); wbData = $urandom;
      #1;
      checks++;
      if ({stall1, regRs1, regRt1} !== {expStall(1'b1), fwdVal(idRsAddress, 1'b1), fwdVal(idRtAddress, 1'b1)}) begin
        errors++; $display("FAIL rand_comb1[%0d]: got st=%0b rs=%h rt=%h want st=%0b rs=%h rt=%h", i,
                           stall1, regRs1, regRt1, expStall(1'b1), fwdVal(idRsAddress, 1'b1), fwdVal(idRtAddress, 1'b1));
      end
      checks++;
      if ({stall0, regRs0, regRt0} !== {expStall(1'b0), fwdVal(idRsAddress, 1'b0), fwdVal(idRtAddress, 1'b0)}) begin
        errors++; $display("FAIL rand_comb0[%0d]: got st=%0b rs=%h rt=%h want st=%0b rs=%h rt=%h", i,
                           stall0, regRs0, regRt0, expStall(1'b0), fwdVal(idRsAddress, 1'b0), fwdVal(idRtAddress, 1'b0));
      end
      tick();
      checks++;
      if ({outValid1, outRs1, outRt1} !== {expValid[1], expRs[1], expRt[1]}) begin
        errors++; $display("FAIL rand_idex1[%0d]: got v=%0b rs=%h rt=%h want v=%0b rs=%h rt=%h", i,
                           outValid1, outRs1, outRt1, expValid[1], expRs[1], expRt[1]);
      end
      checks++;
      if ({outValid0, outRs0, outRt0} !== {expValid[0], expRs[0], expRt[0]}) begin
        errors++; $display("FAIL rand_idex0[%0d]: got v=%0b rs=%h rt=%h want v=%0b rs=%h rt=%h", i,
                           outValid0, outRs0, outRt0, expValid[0], expRs[0], expRt[0]);
      end
      checks++;
      if (dbg1 !== flatRegs() || dbg0 !== flatRegs()) begin
        errors++; $display("FAIL rand_regs[%0d]: r1..r7 got %h want %h", i, dbg1[255:32], flatRegs()[255:32]);
      end
    end
    clearInputs();
  endtask

`ifdef ID_OPERAND_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    checks++;
    if (stallCnt1 !== expStallCnt[1] || fwdCnt1 !== expFwdCnt[1]) begin
      errors++; $display("FAIL perf1: got stall=%0d fwd=%0d want %0d/%0d",
                         stallCnt1, fwdCnt1, expStallCnt[1], expFwdCnt[1]);
    end
    checks++;
    if (stallCnt0 !== expStallCnt[0] || fwdCnt0 !== expFwdCnt[0]) begin
      errors++; $display("FAIL perf0: got stall=%0d fwd=%0d want %0d/%0d",
                         stallCnt0, fwdCnt0, expStallCnt[0], expFwdCnt[0]);
    end
    // Directed: 3 stall cycles then 2 forwarded issues from a fresh reset
    reset = 1'b0;
    #1;
    modelReset();
    clearInputs();
    reset = 1'b1;
    tick();
    idValid = 1; idUsesRs = 1; idRsAddress = 5'd7;
    exWe = 1; exLoad = 1; exAddr = 5'd7;
    repeat (3) tick();
    exLoad = 0; exRes = 32'h1;
    repeat (2) tick();
    checks++;
    if (stallCnt1 !== 32'd3 || fwdCnt1 !== 32'd2) begin
      errors++; $display("FAIL perf_directed: got stall=%0d fwd=%0d want 3/2", stallCnt1, fwdCnt1);
    end
    clearInputs();
  endtask
`endif

  initial begin
    clearInputs();
    test_reset();
    test_regfile();
    test_forwarding();
    test_load_use();
    test_flush_reset();
    test_random();
`ifdef ID_OPERAND_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
